// File: rtl/receiver_if.sv
// receiver_if: bundle between the serial receiver and its line/CPU-side driver
//   master: drives en, baud, rx, rd, clrerr; observes dout, count, empty, full, busy, overrun, ferr
//   slave : the receiver itself
interface receiver_if #(parameter int DEPTH = 4);
   logic en;
   logic [7:0] baud;
   logic rx;
   logic rd;
   logic clrerr;
   logic [7:0] dout;
   logic [$clog2(DEPTH):0] count;
   logic empty;
   logic full;
   logic busy;
   logic overrun;
   logic ferr;
   modport master (output en, baud, rx, rd, clrerr,
                   input dout, count, empty, full, busy, overrun, ferr);
   modport slave (input en, baud, rx, rd, clrerr,
                  output dout, count, empty, full, busy, overrun, ferr);
endinterface

// File: rtl/receiver.sv
// receiver: 8N1 serial receiver with a first-word-fall-through byte FIFO
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)  : en/baud/rx/rd/clrerr in; dout/count/empty/full/busy/overrun/ferr out
module receiver #(parameter int DEPTH = 4) (
   input logic clk,
   input logic reset,
   receiver_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
   logic [1:0] state;
   logic s1, rxs, hist;
   logic [7:0] cnt, sh;
   logic [2:0] idx;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] fill;
   logic at_half, at_full, push, frame_err, pop, wr;
   always_comb begin
      at_half = cnt == (bus.baud >> 1);
      at_full = cnt == bus.baud;
      push = bus.en && state == STOP && at_full && rxs;
      frame_err = bus.en && state == STOP && at_full && !rxs;
      pop = bus.rd && fill != '0;
      wr = push && (fill != FULLV || pop);
   end
   // reset loads the line as idle-high so leaving reset never looks like a start edge
   always_ff @(posedge clk) begin
      if (reset) {s1, rxs, hist} <= '1;
      else begin
         s1 <= bus.rx;
         rxs <= s1;
         hist <= rxs;
      end
   end
   // edge detection in IDLE means a held break cannot retrigger after its framing error
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
      end else if (!bus.en) state <= IDLE;
      else case (state)
         IDLE: if (hist && !rxs) begin
            state <= START;
            cnt <= '0;
         end
         START: if (at_half) begin
            state <= rxs ? IDLE : DATA;
            cnt <= '0;
            idx <= '0;
         end else cnt <= cnt + 8'd1;
         DATA: if (at_full) begin
            sh <= {rxs, sh[7:1]};
            cnt <= '0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
         end else cnt <= cnt + 8'd1;
         default: if (at_full) state <= IDLE;
         else cnt <= cnt + 8'd1;
      endcase
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= sh;
   end
   // when full, a simultaneous pop frees the head slot that wp now points at
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
         fill <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         fill <= fill + (AW+1)'(wr) - (AW+1)'(pop);
      end
   end
   // set events take priority over clrerr on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.overrun <= 1'b0;
         bus.ferr <= 1'b0;
      end else begin
         bus.overrun <= (push && !wr) || (bus.overrun && !bus.clrerr);
         bus.ferr <= frame_err || (bus.ferr && !bus.clrerr);
      end
   end
   assign bus.dout = fill == '0 ? 8'h00 : mem[rp];
   assign bus.count = fill;
   assign bus.empty = fill == '0;
   assign bus.full = fill == FULLV;
   assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: randomized and directed self-checking bench for receiver
module tb_receiver;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   receiver_if #(.DEPTH(DEPTH)) bus();
   receiver #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int total = 0;
   int bad = 0;
   logic [7:0] q[$];
   logic m_ovr = 1'b0;
   logic m_ferr = 1'b0;

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // queue-level effect of one frame: optional pop/clear on its push edge, then the push or error
   task automatic model(input logic [7:0] b, input logic stop, input bit rdp, input bit clrp);
      if (clrp) begin
         m_ovr = 1'b0;
         m_ferr = 1'b0;
      end
      if (rdp && q.size() > 0) void'(q.pop_front());
      if (!stop) m_ferr = 1'b1;
      else if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
   endtask

   // one 8N1 frame, each bit held baud+1 cycles; rd/clrerr optionally land on the push edge
   task automatic send(input logic [7:0] b, input logic stop, input bit rdp, input bit clrp);
      int bp = int'(bus.baud) + 1;
      int pe = 4 + int'(bus.baud >> 1) + 9 * bp;
      logic [9:0] fr = {stop, b, 1'b0};
      for (int t = 0; t < 10 * bp + 4; t++) begin
         bus.rx = t < 10 * bp ? fr[t / bp] : 1'b1;
         bus.rd = rdp && t == pe - 1;
         bus.clrerr = clrp && t == pe - 1;
         tick(1);
      end
      bus.rd = 1'b0;
      bus.clrerr = 1'b0;
      model(b, stop, rdp, clrp);
   endtask

   task automatic pulse_rd();
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic pulse_clr();
      bus.clrerr = 1'b1;
      tick(1);
      bus.clrerr = 1'b0;
      m_ovr = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      q.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      bus.en = 1'b1; bus.rd = 1'b1; bus.clrerr = 1'b1; bus.rx = 1'b1; bus.baud = 8'd9;
      reset = 1'b1;
      tick(2);
      total++; if ({bus.count, bus.empty, bus.full} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL reset_fifo got=%0d/%b/%b want=0/1/0", bus.count, bus.empty, bus.full); end
      total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%0h want=0", bus.dout); end
      total++; if ({bus.busy, bus.overrun, bus.ferr} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.overrun, bus.ferr}); end
      reset = 1'b0; bus.rd = 1'b0; bus.clrerr = 1'b0;
      q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
      tick(2);
   endtask

   task automatic test_frame();
      send(8'hA5, 1'b1, 1'b0, 1'b0);
      total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL a5_count got=%0d want=1", bus.count); end
      total++; if (bus.dout !== 8'hA5) begin bad++; $display("FAIL a5_dout got=%0h want=a5", bus.dout); end
      total++; if ({bus.ferr, bus.busy} !== 2'b00) begin bad++; $display("FAIL a5_ferr_busy got=%b want=00", {bus.ferr, bus.busy}); end
      pulse_rd();
      total++; if ({bus.empty, bus.dout} !== {1'b1, 8'h00}) begin bad++; $display("FAIL a5_drain got=%b/%0h want=1/0", bus.empty, bus.dout); end
   endtask

   task automatic test_false_start();
      bus.rx = 1'b0;
      tick(3);
      bus.rx = 1'b1;
      tick(2);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL fs_busy_mid got=%b want=1", bus.busy); end
      tick(12);
      total++; if ({bus.busy, bus.count, bus.overrun, bus.ferr} !== {1'b0, 3'd0, 2'b00}) begin bad++; $display("FAIL fs_idle got=%b/%0d/%b/%b want=0/0/0/0", bus.busy, bus.count, bus.overrun, bus.ferr); end
   endtask

   task automatic test_ferr();
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      total++; if ({bus.ferr, bus.count} !== {1'b1, 3'd0}) begin bad++; $display("FAIL ferr_set got=%b/%0d want=1/0", bus.ferr, bus.count); end
      pulse_clr();
      total++; if (bus.ferr !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%b want=0", bus.ferr); end
      send(8'h3C, 1'b0, 1'b0, 1'b1);
      total++; if (bus.ferr !== m_ferr) begin bad++; $display("FAIL ferr_set_wins got=%b want=%b", bus.ferr, m_ferr); end
      pulse_clr();
   endtask

   task automatic test_break();
      int bp = int'(bus.baud) + 1;
      bus.rx = 1'b0;
      tick(12 * bp);
      total++; if ({bus.ferr, bus.busy} !== 2'b10) begin bad++; $display("FAIL break_first got=%b want=10", {bus.ferr, bus.busy}); end
      pulse_clr();
      tick(20 * bp);
      total++; if ({bus.ferr, bus.busy, bus.count} !== {2'b00, 3'd0}) begin bad++; $display("FAIL break_once got=%b/%b/%0d want=0/0/0", bus.ferr, bus.busy, bus.count); end
      bus.rx = 1'b1;
      tick(4);
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
      total++; if ({bus.count, bus.full, bus.overrun} !== {3'd4, 2'b11}) begin bad++; $display("FAIL ovr_state got=%0d/%b/%b want=4/1/1", bus.count, bus.full, bus.overrun); end
      for (int i = 1; i <= 4; i++) begin
         total++; if (bus.dout !== 8'(i)) begin bad++; $display("FAIL ovr_pop%0d got=%0h want=%0h", i, bus.dout, i); end
         pulse_rd();
      end
      total++; if ({bus.empty, bus.dout} !== {1'b1, 8'h00}) begin bad++; $display("FAIL ovr_empty got=%b/%0h want=1/0", bus.empty, bus.dout); end
      pulse_clr();
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
      send(8'h11, 1'b1, 1'b0, 1'b0); send(8'h22, 1'b1, 1'b0, 1'b0);
      send(8'h33, 1'b1, 1'b0, 1'b0); send(8'h44, 1'b1, 1'b0, 1'b0);
      send(8'h55, 1'b1, 1'b1, 1'b0);
      total++; if ({bus.count, bus.full, bus.overrun} !== {3'd4, 2'b10}) begin bad++; $display("FAIL fpp_state got=%0d/%b/%b want=4/1/0", bus.count, bus.full, bus.overrun); end
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.dout !== exp[i]) begin bad++; $display("FAIL fpp_pop%0d got=%0h want=%0h", i, bus.dout, exp[i]); end
         pulse_rd();
      end
   endtask

   task automatic test_push_rd_empty();
      send(8'h66, 1'b1, 1'b1, 1'b0);
      total++; if ({bus.count, bus.dout} !== {3'd1, 8'h66}) begin bad++; $display("FAIL pre_state got=%0d/%0h want=1/66", bus.count, bus.dout); end
      pulse_rd();
   endtask

   task automatic test_en_drop();
      int bp = int'(bus.baud) + 1;
      send(8'h77, 1'b1, 1'b0, 1'b0);
      bus.rx = 1'b0;
      tick(3 * bp);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL en_busy_mid got=%b want=1", bus.busy); end
      bus.en = 1'b0;
      tick(1);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL en_idle got=%b want=0", bus.busy); end
      bus.rx = 1'b1;
      tick(8 * bp);
      bus.en = 1'b1;
      tick(2);
      total++; if ({bus.count, bus.dout, bus.ferr, bus.busy} !== {3'd1, 8'h77, 2'b00}) begin bad++; $display("FAIL en_kept got=%0d/%0h/%b/%b want=1/77/0/0", bus.count, bus.dout, bus.ferr, bus.busy); end
      pulse_rd();
   endtask

   task automatic test_reset_mid();
      int bp = int'(bus.baud) + 1;
      send(8'h12, 1'b1, 1'b0, 1'b0);
      send(8'h34, 1'b1, 1'b0, 1'b0);
      bus.rx = 1'b0;
      tick(3 * bp);
      reset = 1'b1;
      bus.rx = 1'b1;
      tick(1);
      total++; if ({bus.count, bus.dout, bus.busy, bus.empty} !== {3'd0, 8'h00, 2'b01}) begin bad++; $display("FAIL rmid_state got=%0d/%0h/%b/%b want=0/0/0/1", bus.count, bus.dout, bus.busy, bus.empty); end
      reset = 1'b0;
      q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
      tick(3);
      send(8'h7E, 1'b1, 1'b0, 1'b0);
      total++; if ({bus.count, bus.dout, bus.ferr} !== {3'd1, 8'h7E, 1'b0}) begin bad++; $display("FAIL rmid_7e got=%0d/%0h/%b want=1/7e/0", bus.count, bus.dout, bus.ferr); end
      pulse_rd();
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic [7:0] b = 8'($urandom);
         logic stop = $urandom_range(0, 5) != 0;
         bit rdp = $urandom_range(0, 3) == 0;
         bit clrp = $urandom_range(0, 5) == 0;
         bus.en = 1'b0;
         bus.baud = 8'($urandom_range(3, 20));
         tick(1);
         bus.en = 1'b1;
         tick(2);
         send(b, stop, rdp, clrp);
         total++; if (bus.count !== 3'(q.size())) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, bus.count, q.size()); end
         total++; if (bus.dout !== (q.size() > 0 ? q[0] : 8'h00)) begin bad++; $display("FAIL rnd%0d_dout got=%0h want=%0h", it, bus.dout, q.size() > 0 ? q[0] : 8'h00); end
         total++; if ({bus.overrun, bus.ferr} !== {m_ovr, m_ferr}) begin bad++; $display("FAIL rnd%0d_flags got=%b%b want=%b%b", it, bus.overrun, bus.ferr, m_ovr, m_ferr); end
         total++; if ({bus.full, bus.empty, bus.busy} !== {q.size() == DEPTH, q.size() == 0, 1'b0}) begin bad++; $display("FAIL rnd%0d_status got=%b%b%b want=%b%b0", it, bus.full, bus.empty, bus.busy, q.size() == DEPTH, q.size() == 0); end
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            total++; if (bus.dout !== (q.size() > 0 ? q[0] : 8'h00)) begin bad++; $display("FAIL rnd%0d_pop got=%0h want=%0h", it, bus.dout, q.size() > 0 ? q[0] : 8'h00); end
            pulse_rd();
         end
         if ($urandom_range(0, 4) == 0) pulse_clr();
      end
   endtask

   initial begin
      bus.en = 1'b0; bus.baud = 8'd9; bus.rx = 1'b1; bus.rd = 1'b0; bus.clrerr = 1'b0;
      tick(2);
      test_reset();
      test_frame();
      test_false_start();
      test_ferr();
      test_break();
      test_overrun();
      test_full_push_pop();
      test_push_rd_empty();
      test_en_drop();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
